// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register bank slave.
package apb_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // Number of byte-offset address bits below the word index.
    function automatic int BYTE_OFS_W(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter used to insert APB wait states; saturates at zero.
module apb_wait_ctr #(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero,
    output logic [WAIT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 slave: DEPTH-word register bank, programmable wait states, PSLVERR on out-of-range.
// Define APB_SLAVE_PSTRB_EN to add APB4 byte strobes (pstrb) on writes.
module apb_slave_regbank import apb_regbank_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int WAIT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                psel,
    input  logic                penable,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_SLAVE_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    input  logic [WAIT_W-1:0]   wait_cycles,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr
);

    localparam int NB     = DATA_W / 8;
    localparam int OFS_W  = BYTE_OFS_W(DATA_W);
    localparam int IDX_W  = ADDR_W - OFS_W;
    localparam int RIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e        state, state_nx;
    logic [IDX_W-1:0]  idx_in, idx_q;
    logic [RIDX_W-1:0] ridx;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     strb_in, strb_q;
    logic              capture, done, dec, oor, rdy_nx;
    logic              cnt_zero;
    logic [WAIT_W-1:0] cnt;
    logic [DATA_W-1:0] regs [DEPTH];

`ifdef APB_SLAVE_PSTRB_EN
    assign strb_in = pstrb;
`else
    assign strb_in = '1;
`endif

    assign idx_in = IDX_W'(paddr >> OFS_W);
    assign oor    = {1'b0, idx_q} >= (IDX_W + 1)'(DEPTH);
    assign ridx   = oor ? '0 : RIDX_W'(idx_q);

    apb_wait_ctr #(.WAIT_W(WAIT_W)) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (capture),
        .load_val (wait_cycles),
        .dec      (dec),
        .zero     (cnt_zero),
        .cnt      (cnt)
    );

    // A completing ACCESS may chain straight into the next SETUP.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        done     = 1'b0;
        dec      = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nx = SETUP;
                    capture  = 1'b1;
                end
            end
            SETUP: state_nx = ACCESS;
            ACCESS: begin
                if (cnt_zero) begin
                    done = 1'b1;
                    if (psel && !penable) begin
                        state_nx = SETUP;
                        capture  = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (!psel || !penable) begin
                    state_nx = IDLE;
                end else begin
                    dec = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // pready is registered, so it is raised on the edge entering the last ACCESS cycle.
    assign rdy_nx = (state == SETUP && cnt_zero) || (dec && cnt == WAIT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= RESP_OK;
        end else begin
            state <= state_nx;
            if (capture) begin
                idx_q   <= idx_in;
                wr_q    <= pwrite;
                wdata_q <= pwdata;
                strb_q  <= strb_in;
            end
            pready  <= rdy_nx;
            pslverr <= (rdy_nx && oor) ? RESP_ERR : RESP_OK;
            prdata  <= (rdy_nx && !wr_q && !oor) ? regs[ridx] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (done && wr_q && !oor) begin
            for (int b = 0; b < NB; b++)
                if (strb_q[b])
                    regs[ridx][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: per-cycle timeline model plus literal checks.
module tb_apb_slave_regbank;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int WAIT_W = 4;
    localparam int MAXC   = 2048;

    logic              clk = 1'b0;
    logic              reset;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [WAIT_W-1:0] wait_cycles;
`ifdef APB_SLAVE_PSTRB_EN
    logic [3:0]        pstrb;
`endif
    logic              pready, pslverr;
    logic [DATA_W-1:0] prdata;

    apb_slave_regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_W(WAIT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .psel        (psel),
        .penable     (penable),
        .paddr       (paddr),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
`ifdef APB_SLAVE_PSTRB_EN
        .pstrb       (pstrb),
`endif
        .wait_cycles (wait_cycles),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Expected outputs per cycle number; everything not marked is expected idle (all zero).
    bit        e_rdy [MAXC];
    bit        e_err [MAXC];
    bit        e_wrc [MAXC];
    bit [31:0] e_rd  [MAXC];
    bit [31:0] mem   [DEPTH];

    int        nvec = 0, nfail = 0;
    int        last_cyc;
    bit [31:0] last_rd;
    bit        last_err;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            nvec++;
            if (pready !== e_rdy[cyc]) begin
                nfail++;
                $display("FAIL pready cyc=%0d got=%b want=%b", cyc, pready, e_rdy[cyc]);
            end
            nvec++;
            if (pslverr !== e_err[cyc]) begin
                nfail++;
                $display("FAIL pslverr cyc=%0d got=%b want=%b", cyc, pslverr, e_err[cyc]);
            end
            if (!e_wrc[cyc]) begin
                nvec++;
                if (prdata !== e_rd[cyc]) begin
                    nfail++;
                    $display("FAIL prdata cyc=%0d got=%h want=%h", cyc, prdata, e_rd[cyc]);
                end
            end
            if (pready === 1'b1) begin
                last_cyc = cyc;
                last_rd  = prdata;
                last_err = pslverr;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One APB transfer starting with its setup phase in the current cycle.
    // b2b=1 returns in the completing cycle so the next call chains without a gap.
    task automatic xfer(input bit we, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] st, input int n, input bit b2b, output int t0);
        int tc, idx;
        t0  = cyc;
        tc  = t0 + 2 + n;
        idx = int'(a) / 4;
        last_cyc = -1;
        e_rdy[tc] = 1'b1;
        if (idx >= DEPTH) begin
            e_err[tc] = 1'b1;
            if (we) e_wrc[tc] = 1'b1;
        end else if (we) begin
            e_wrc[tc] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (st[b]) mem[idx][b*8 +: 8] = d[b*8 +: 8];
        end else begin
            e_rd[tc] = mem[idx];
        end
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = we; pwdata = d;
        wait_cycles = n[3:0];
`ifdef APB_SLAVE_PSTRB_EN
        pstrb = st;
`endif
        step();
        // Scramble everything the slave must have latched already.
        penable = 1'b1; paddr = ~a; pwdata = ~d; pwrite = ~we; wait_cycles = ~n[3:0];
`ifdef APB_SLAVE_PSTRB_EN
        pstrb = ~st;
`endif
        repeat (n + 1) step();
        if (!b2b) begin
            step();
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    initial begin
        int ta, tb;
        for (int i = 0; i < MAXC; i++) begin
            e_rdy[i] = 0; e_err[i] = 0; e_wrc[i] = 0; e_rd[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; wait_cycles = '0;
`ifdef APB_SLAVE_PSTRB_EN
        pstrb = '0;
`endif
        repeat (3) step();
        lit("reset_pready", {31'd0, pready}, 32'd0);
        lit("reset_prdata", prdata, 32'd0);
        reset = 1'b1;
        step();

        // Read idx 3 after reset, zero wait states.
        xfer(0, 8'h0C, 32'h0, 4'hF, 0, 0, ta);
        lit("rd0C_latency", 32'(last_cyc - ta), 32'd2);
        lit("rd0C_prdata", last_rd, 32'h0);
        lit("rd0C_pslverr", {31'd0, last_err}, 32'd0);

        // Write with three wait states: four ACCESS cycles after SETUP.
        xfer(1, 8'h08, 32'hDEADBEEF, 4'hF, 3, 0, ta);
        lit("wr08_latency", 32'(last_cyc - ta), 32'd5);
        xfer(0, 8'h08, 32'h0, 4'hF, 0, 0, ta);
        lit("rd08_prdata", last_rd, 32'hDEADBEEF);

        // Low address bits ignored: 0x3F is idx 15.
        xfer(1, 8'h3F, 32'h0F0F0F0F, 4'hF, 1, 0, ta);
        xfer(0, 8'h3C, 32'h0, 4'hF, 0, 0, ta);
        lit("rd3C_prdata", last_rd, 32'h0F0F0F0F);

        // Out-of-range write and read.
        xfer(1, 8'h40, 32'hCAFEF00D, 4'hF, 0, 0, ta);
        lit("wr40_pslverr", {31'd0, last_err}, 32'd1);
        xfer(0, 8'hFC, 32'h0, 4'hF, 2, 0, ta);
        lit("rdFC_pslverr", {31'd0, last_err}, 32'd1);
        lit("rdFC_prdata", last_rd, 32'h0);
        for (int i = 0; i < DEPTH; i++)
            xfer(0, 8'(i * 4), 32'h0, 4'hF, i % 3, i < DEPTH - 1, ta);

        // Back-to-back writes with psel held high.
        xfer(1, 8'h00, 32'h01234567, 4'hF, 0, 1, ta);
        xfer(1, 8'h04, 32'h89ABCDEF, 4'hF, 0, 0, tb);
        lit("b2b_gap", 32'(tb - ta), 32'd2);
        xfer(0, 8'h00, 32'h0, 4'hF, 0, 1, ta);
        xfer(0, 8'h04, 32'h0, 4'hF, 0, 0, ta);
        lit("rd04_prdata", last_rd, 32'h89ABCDEF);

        // Abort: psel dropped in the 2nd ACCESS cycle of a wait-5 write.
        xfer(1, 8'h10, 32'h44444444, 4'hF, 0, 0, ta);
        psel = 1'b1; penable = 1'b0; paddr = 8'h10; pwrite = 1'b1;
        pwdata = 32'h12345678; wait_cycles = 4'd5;
        step();
        penable = 1'b1;
        step();
        step();
        psel = 1'b0; penable = 1'b0;
        repeat (3) step();
        xfer(0, 8'h10, 32'h0, 4'hF, 0, 0, ta);
        lit("abort_reg4", last_rd, 32'h44444444);

        // psel+penable from IDLE without a setup phase is ignored.
        psel = 1'b1; penable = 1'b1; paddr = 8'h14; pwrite = 1'b1; pwdata = 32'hBAD0BAD0;
        repeat (3) step();
        psel = 1'b0; penable = 1'b0;
        step();
        xfer(0, 8'h14, 32'h0, 4'hF, 0, 0, ta);
        lit("idle_ignore_reg5", last_rd, 32'h0);

`ifdef APB_SLAVE_PSTRB_EN
        xfer(1, 8'h20, 32'hAABBCCDD, 4'hF, 0, 0, ta);
        xfer(1, 8'h20, 32'h11223344, 4'b0101, 1, 0, ta);
        xfer(0, 8'h20, 32'h0, 4'hF, 0, 0, ta);
        lit("pstrb_merge", last_rd, 32'hAA22CC44);
        xfer(1, 8'h20, 32'hFFFFFFFF, 4'b0000, 0, 0, ta);
        lit("pstrb_zero_err", {31'd0, last_err}, 32'd0);
        xfer(0, 8'h20, 32'h0, 4'hF, 0, 0, ta);
        lit("pstrb_zero_keep", last_rd, 32'hAA22CC44);
`endif

        // Reset asserted while a read completes: outputs clear without waiting for an edge.
        xfer(0, 8'h08, 32'h0, 4'hF, 0, 1, ta);
        #6;
        reset = 1'b0;
        #1;
        lit("async_rst_pready", {31'd0, pready}, 32'd0);
        lit("async_rst_prdata", prdata, 32'd0);
        lit("async_rst_pslverr", {31'd0, pslverr}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (2) step();
        reset = 1'b1;
        step();
        xfer(0, 8'h08, 32'h0, 4'hF, 0, 0, ta);
        lit("post_rst_reg2", last_rd, 32'h0);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- Parametrised APB3 slave: DEPTH-word register bank behind a 3-state APB FSM.
- Supports a programmable wait-state count, PSLVERR on out-of-range access, and abort on protocol violation.
- Serves as the synthesizable DUT behind the existing APB interface and UVM env; it generalises the fixed 8-bit address / 32-bit data slave in width, depth and timing.

Parameters:
- ADDR_W, 8, paddr width in bits.
- DATA_W, 32, pwdata/prdata width; must be 8, 16, 32 or 64.
- DEPTH, 16, number of DATA_W-bit registers; 1..2**(ADDR_W-log2(DATA_W/8)).
- WAIT_W, 4, width of the wait_cycles input.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous active-low reset (0 = in reset).
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- paddr  in  ADDR_W  byte address.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  DATA_W  write data.
- wait_cycles  in  WAIT_W  wait states inserted per access; sampled in SETUP.
- pready  out  1  transfer complete, registered.
- prdata  out  DATA_W  read data, registered; valid only when pready=1 and pwrite=0.
- pslverr  out  1  error response, registered; valid only when pready=1.

Behaviour:
- Reset (reset=0, async): FSM to IDLE; pready=0, prdata=0, pslverr=0, wait counter=0; all DEPTH registers cleared to 0.
- Word index: idx = paddr >> log2(DATA_W/8). Low address bits are ignored. Out of range when idx >= DEPTH.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when psel=1 and penable=0.
  - psel=1 and penable=1 in IDLE is ignored; stay in IDLE.
  - SETUP: latch paddr, pwrite, pwdata and wait_cycles (cnt=wait_cycles).
  - SETUP -> ACCESS unconditionally.
  - ACCESS: while cnt!=0, decrement cnt with pready=0.
  - ACCESS, cnt==0: complete the transfer; pready=1 for exactly one cycle.
- Latency: with wait_cycles=N, ACCESS lasts N+1 cycles; pready is high in the last one. Minimum (N=0) is SETUP + 1 ACCESS cycle, matching APB zero-wait timing.
- Write completion (in range): reg[idx] <= latched pwdata at the completing edge; pslverr=0.
- Read completion (in range): prdata = reg[idx]; pslverr=0.
- Out-of-range completion: pslverr=1, prdata=0, no register modified.
- prdata returns to 0 the cycle after completion; pslverr returns to 0 with pready.
- After completion:
  - psel=1, penable=0 -> SETUP (back-to-back, no idle cycle needed).
  - otherwise -> IDLE.
- Abort: psel=0 or penable=0 while in ACCESS before completion -> IDLE, no write, pready stays 0.
- Changes to paddr/pwdata/pwrite during ACCESS are ignored (latched values are used).
- Reset asserted mid-transfer: immediate return to reset values; the partial write is discarded.
- Reads are not destructive; a read in the same cycle as a write to the same register is impossible (single port).

Optional Feature:
- Macro: APB_SLAVE_PSTRB_EN.
- Defined:
  - adds port pstrb, in, DATA_W/8, APB4 byte strobes.
  - latched in SETUP; a write updates only bytes whose strobe is 1.
  - pstrb=0 on a write completes normally with no change.
  - strobes are ignored on reads.
- Undefined: no pstrb port; writes update the full word.

Decomposition:
- Package apb_regbank_pkg:
  - state enum apb_state_e {IDLE, SETUP, ACCESS}.
  - function clog2-based BYTE_OFS_W(DATA_W).
  - localparam error/OK codes for pslverr.
- One sub-module: apb_wait_ctr, the loadable down-counter (load, dec, zero flag), width WAIT_W.
- The register array stays in the top module.

Test Plan:
- Reset then read idx 3 (paddr=0x0C), wait_cycles=0 -> pready in 1st ACCESS cycle, prdata=0, pslverr=0.
- Write 0xDEADBEEF to paddr=0x08 with wait_cycles=3, then read 0x08 -> write pready after 4 ACCESS cycles; read prdata=0xDEADBEEF.
- Write to paddr=0x40 (idx 16, DEPTH=16) -> pready=1 with pslverr=1; subsequent reads of all 16 registers are unchanged.
- Back-to-back writes to 0x00 and 0x04 with psel held high, wait_cycles=0 -> each completes in 2 cycles, no idle gap, both values read back.
- Drop psel in the 2nd ACCESS cycle of a write to 0x10 (wait_cycles=5) -> FSM to IDLE, pready never asserted, reg[4] unchanged; then assert reset mid-write -> all outputs 0 asynchronously.
- APB_SLAVE_PSTRB_EN: write 0x11223344 with pstrb=4'b0101 over 0xAABBCCDD -> readback 0xAA22CC44.
